stream_buffer_single_control: RTL and testbench
===============================================

STREAM_BUFFER_SINGLE_CONTROL -- requirements
Module: stream_buffer_single_control

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 26, width of a cache-line address.
REQ-002 SHALL have parameter n, default 1, buffer depth 2^n lines.
REQ-003 SHALL have parameter p, default 2, maximum in-flight prefetches 2^p.
REQ-004 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ENB  in  1  clock enable; low freezes all state.
REQ-007 SHALL have port BUFFER_RESET  in  1  synchronous reallocation to a new stream.
REQ-008 SHALL have port INIT_TOQ_VALUE  in  ADDR_WIDTH  first line address of the new stream.
REQ-009 SHALL have port ADDR_IN  in  ADDR_WIDTH  line address probed for a hit.
REQ-010 SHALL have port STREAM_BUFFER_HIT  out  1  head line present and equal to ADDR_IN.
REQ-011 SHALL have port HIT_COMMIT  in  1  head line consumed by L1.
REQ-012 SHALL have port PREFETCH_VALID  out  1  a new prefetch may be issued.
REQ-013 SHALL have port PREFETCH_REQUESTED  in  1  prefetch at NEXT_REQ accepted this cycle.
REQ-014 SHALL have port PREFETCH_COMMITED  in  1  one prefetched line fully delivered.
REQ-015 SHALL have port REFILL_ENB  out  1  delivered line may be written into the buffer.
REQ-016 SHALL have port NEXT_REQ  out  ADDR_WIDTH  address of the next prefetch.

Function
REQ-017 SHALL hold state: valid flag, toq (head address), next_req, present count (0..2^n), inflight count (0..2^p), stale count (p+2 bits).
REQ-018 STREAM_BUFFER_HIT SHALL be combinational: valid & present>0 & ADDR_IN==toq.
REQ-019 PREFETCH_VALID SHALL be combinational: valid & (present+inflight)<2^n & inflight<2^p.
REQ-020 REFILL_ENB SHALL be combinational: valid & stale==0; NEXT_REQ SHALL equal the next_req register.
REQ-021 On ENB & BUFFER_RESET: valid<=1, toq<=INIT_TOQ_VALUE, next_req<=INIT_TOQ_VALUE, present<=0, inflight<=0, stale<=stale+inflight+PREFETCH_REQUESTED-PREFETCH_COMMITED; HIT_COMMIT ignored; takes priority over all other updates.
REQ-022 Otherwise on ENB & HIT_COMMIT & present>0: toq<=toq+1, present decrements.
REQ-023 Otherwise on ENB & PREFETCH_REQUESTED: next_req<=next_req+1, inflight increments.
REQ-024 Otherwise on ENB & PREFETCH_COMMITED: if stale>0, stale decrements only (line discarded); else inflight decrements and present increments.
REQ-025 Simultaneous HIT_COMMIT, PREFETCH_REQUESTED, PREFETCH_COMMITED SHALL all apply in the same cycle as net counter changes.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-027 HIT_COMMIT with present==0, PREFETCH_REQUESTED with PREFETCH_VALID low, and non-stale PREFETCH_COMMITED with inflight==0 SHALL be ignored (no counter underflow/overflow).
REQ-028 With ENB low, no register SHALL change; outputs follow current state.

Reset
REQ-029 RST high SHALL asynchronously clear valid, toq, next_req, present, inflight, stale to 0.
REQ-030 After RST: STREAM_BUFFER_HIT=0, PREFETCH_VALID=0, REFILL_ENB=0, NEXT_REQ=0 until first BUFFER_RESET.
REQ-031 RST SHALL override ENB and BUFFER_RESET.

Configuration
REQ-032 Macro SBSC_STALE_DISCARD_EN defined: stale counting per REQ-021/REQ-024 compiled in.
REQ-033 Macro undefined: stale register absent, BUFFER_RESET discards inflight, REFILL_ENB=valid, every PREFETCH_COMMITED after reset treated as non-stale per REQ-024/REQ-027.

Verification
REQ-034 RST, BUFFER_RESET INIT_TOQ_VALUE=0x100 -> NEXT_REQ=0x100, PREFETCH_VALID=1, HIT=0 for ADDR_IN=0x100.
REQ-035 Two PREFETCH_REQUESTED (n=1) -> NEXT_REQ=0x102, PREFETCH_VALID=0; one PREFETCH_COMMITED -> HIT=1 at ADDR_IN=0x100, 0 at 0x101.
REQ-036 HIT_COMMIT -> HIT at 0x100 =0, PREFETCH_VALID=1; second PREFETCH_COMMITED -> HIT=1 at 0x101.
REQ-037 INIT_TOQ_VALUE=0x3FFFFFF, one PREFETCH_REQUESTED -> NEXT_REQ=0x0000000.
REQ-038 (macro defined) BUFFER_RESET INIT 0x200 with inflight=2 -> next two PREFETCH_COMMITED see REFILL_ENB=0 and HIT stays 0; REFILL_ENB=1 after.
REQ-039 ENB=0 with HIT_COMMIT, PREFETCH_REQUESTED pulsed -> toq, NEXT_REQ, HIT unchanged.

Source files
------------

// File: rtl/stream_buffer_single_control_if.sv
// Handshake/bus bundle for the stream buffer: L1 probe/commit, prefetch issue/delivery.
// master = controller driving the buffer, slave = the buffer itself.
interface stream_buffer_single_control_if #(
   parameter int ADDR_WIDTH = 26
);
   logic                  ENB;
   logic                  BUFFER_RESET;
   logic [ADDR_WIDTH-1:0] INIT_TOQ_VALUE;
   logic [ADDR_WIDTH-1:0] ADDR_IN;
   logic                  STREAM_BUFFER_HIT;
   logic                  HIT_COMMIT;
   logic                  PREFETCH_VALID;
   logic                  PREFETCH_REQUESTED;
   logic                  PREFETCH_COMMITED;
   logic                  REFILL_ENB;
   logic [ADDR_WIDTH-1:0] NEXT_REQ;

   modport master (
      output ENB, BUFFER_RESET, INIT_TOQ_VALUE, ADDR_IN, HIT_COMMIT,
             PREFETCH_REQUESTED, PREFETCH_COMMITED,
      input  STREAM_BUFFER_HIT, PREFETCH_VALID, REFILL_ENB, NEXT_REQ
   );
   modport slave (
      input  ENB, BUFFER_RESET, INIT_TOQ_VALUE, ADDR_IN, HIT_COMMIT,
             PREFETCH_REQUESTED, PREFETCH_COMMITED,
      output STREAM_BUFFER_HIT, PREFETCH_VALID, REFILL_ENB, NEXT_REQ
   );
endinterface

// File: rtl/stream_buffer_single_control.sv
// Single stream-buffer controller: tracks head line, next prefetch address and line counts.
// Define SBSC_STALE_DISCARD_EN to drop prefetches still in flight across a BUFFER_RESET.
module stream_buffer_single_control #(
   parameter int ADDR_WIDTH = 26,
   parameter int n          = 1,
   parameter int p          = 2
) (
   input logic CLK,
   input logic RST,
   stream_buffer_single_control_if.slave sb
);
   localparam int DEPTH  = 2 ** n;
   localparam int MAXINF = 2 ** p;
   localparam int PW     = n + 1;
   localparam int IW     = p + 1;

   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] toq_q, toq_d;
   logic [ADDR_WIDTH-1:0] nreq_q, nreq_d;
   logic [PW-1:0]         present_q, present_d;
   logic [IW-1:0]         inflight_q, inflight_d;
   logic                  hit_take, req_take, fill_take, pf_valid;

`ifdef SBSC_STALE_DISCARD_EN
   localparam int SW = p + 2;
   logic [SW-1:0] stale_q, stale_d;
   logic          stale_take;
   int            stale_sum;
`endif

   // Outputs are pure functions of state (and ADDR_IN for the hit probe)
   always_comb begin
      pf_valid = valid_q && ((int'(present_q) + int'(inflight_q)) < DEPTH)
                         && (int'(inflight_q) < MAXINF);
   end

   assign sb.STREAM_BUFFER_HIT = valid_q && (present_q != '0) && (sb.ADDR_IN == toq_q);
   assign sb.PREFETCH_VALID    = pf_valid;
   assign sb.NEXT_REQ          = nreq_q;
`ifdef SBSC_STALE_DISCARD_EN
   assign sb.REFILL_ENB        = valid_q && (stale_q == '0);
`else
   assign sb.REFILL_ENB        = valid_q;
`endif

   always_comb begin
      hit_take  = sb.HIT_COMMIT && (present_q != '0);
      req_take  = sb.PREFETCH_REQUESTED && pf_valid;
`ifdef SBSC_STALE_DISCARD_EN
      stale_take = sb.PREFETCH_COMMITED && (stale_q != '0);
      fill_take  = sb.PREFETCH_COMMITED && (stale_q == '0) && (inflight_q != '0);
`else
      fill_take  = sb.PREFETCH_COMMITED && (inflight_q != '0);
`endif
   end

   always_comb begin
      valid_d    = valid_q;
      toq_d      = toq_q;
      nreq_d     = nreq_q;
      present_d  = present_q;
      inflight_d = inflight_q;
`ifdef SBSC_STALE_DISCARD_EN
      stale_d    = stale_q;
      stale_sum  = 0;
`endif
      if (sb.ENB) begin
         if (sb.BUFFER_RESET) begin
            valid_d    = 1'b1;
            toq_d      = sb.INIT_TOQ_VALUE;
            nreq_d     = sb.INIT_TOQ_VALUE;
            present_d  = '0;
            inflight_d = '0;
`ifdef SBSC_STALE_DISCARD_EN
            // Everything still travelling toward the old stream must be dropped on arrival
            stale_sum = int'(stale_q) + int'(inflight_q) + int'(req_take);
            if (sb.PREFETCH_COMMITED && stale_sum > 0) stale_sum = stale_sum - 1;
            stale_d = SW'(stale_sum);
`endif
         end else begin
            if (hit_take) toq_d = toq_q + ADDR_WIDTH'(1);
            if (req_take) nreq_d = nreq_q + ADDR_WIDTH'(1);
            present_d  = PW'(int'(present_q) + int'(fill_take) - int'(hit_take));
            inflight_d = IW'(int'(inflight_q) + int'(req_take) - int'(fill_take));
`ifdef SBSC_STALE_DISCARD_EN
            if (stale_take) stale_d = stale_q - SW'(1);
`endif
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q    <= 1'b0;
         toq_q      <= '0;
         nreq_q     <= '0;
         present_q  <= '0;
         inflight_q <= '0;
`ifdef SBSC_STALE_DISCARD_EN
         stale_q    <= '0;
`endif
      end else begin
         valid_q    <= valid_d;
         toq_q      <= toq_d;
         nreq_q     <= nreq_d;
         present_q  <= present_d;
         inflight_q <= inflight_d;
`ifdef SBSC_STALE_DISCARD_EN
         stale_q    <= stale_d;
`endif
      end
   end
endmodule

// File: tb/tb_stream_buffer_single_control.sv
// Directed table-driven bench for stream_buffer_single_control (n=1, p=2, 26-bit addresses).
module tb_stream_buffer_single_control;
   localparam int AW = 26;
`ifdef SBSC_STALE_DISCARD_EN
   localparam bit STALE = 1'b1;
`else
   localparam bit STALE = 1'b0;
`endif

   typedef struct {
      bit          enb, brst;
      logic [AW-1:0] init, addr;
      bit          hc, pr, pc;
      bit          e_hit, e_pv, e_ref;
      logic [AW-1:0] e_nreq;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   nvec = 0;
   int   nmis = 0;

   stream_buffer_single_control_if #(.ADDR_WIDTH(AW)) sbif ();

   stream_buffer_single_control #(.ADDR_WIDTH(AW), .n(1), .p(2)) dut (
      .CLK(clk), .RST(rst), .sb(sbif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input bit hit, input bit pv, input bit rf,
                             input logic [AW-1:0] nr);
      nvec++;
      chk({tag, ".hit"},  AW'(sbif.STREAM_BUFFER_HIT), AW'(hit));
      chk({tag, ".pv"},   AW'(sbif.PREFETCH_VALID),    AW'(pv));
      chk({tag, ".ref"},  AW'(sbif.REFILL_ENB),        AW'(rf));
      chk({tag, ".nreq"}, sbif.NEXT_REQ,               nr);
   endtask

   // Drive at negedge, check combinational outputs 1ns later; the following posedge commits
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      sbif.ENB = v.enb; sbif.BUFFER_RESET = v.brst; sbif.INIT_TOQ_VALUE = v.init;
      sbif.ADDR_IN = v.addr; sbif.HIT_COMMIT = v.hc;
      sbif.PREFETCH_REQUESTED = v.pr; sbif.PREFETCH_COMMITED = v.pc;
      #1;
      check_outs(tag, v.e_hit, v.e_pv, v.e_ref, v.e_nreq);
   endtask

   function automatic vec_t mk(bit enb, bit brst, logic [AW-1:0] init, logic [AW-1:0] addr,
                               bit hc, bit pr, bit pc, bit eh, bit ep, bit er,
                               logic [AW-1:0] en);
      vec_t v;
      v.enb = enb; v.brst = brst; v.init = init; v.addr = addr;
      v.hc = hc; v.pr = pr; v.pc = pc;
      v.e_hit = eh; v.e_pv = ep; v.e_ref = er; v.e_nreq = en;
      return v;
   endfunction

   vec_t tbl[28];

   initial begin
      //             enb brst init       addr       hc pr pc  hit pv ref nreq
      tbl[0]  = mk(1, 0, 26'h0,      26'h0,      0, 0, 0,  0, 0, 0, 26'h0);
      tbl[1]  = mk(1, 1, 26'h100,    26'h100,    0, 0, 0,  0, 0, 0, 26'h0);
      tbl[2]  = mk(1, 0, 26'h0,      26'h100,    0, 1, 0,  0, 1, 1, 26'h100);
      tbl[3]  = mk(1, 0, 26'h0,      26'h100,    0, 1, 0,  0, 1, 1, 26'h101);
      tbl[4]  = mk(1, 0, 26'h0,      26'h100,    0, 0, 0,  0, 0, 1, 26'h102);
      tbl[5]  = mk(1, 0, 26'h0,      26'h100,    0, 0, 1,  0, 0, 1, 26'h102);
      tbl[6]  = mk(1, 0, 26'h0,      26'h100,    0, 0, 0,  1, 0, 1, 26'h102);
      tbl[7]  = mk(1, 0, 26'h0,      26'h101,    0, 0, 0,  0, 0, 1, 26'h102);
      tbl[8]  = mk(1, 0, 26'h0,      26'h100,    1, 0, 0,  1, 0, 1, 26'h102);
      tbl[9]  = mk(1, 0, 26'h0,      26'h100,    0, 0, 0,  0, 1, 1, 26'h102);
      tbl[10] = mk(1, 0, 26'h0,      26'h101,    0, 0, 1,  0, 1, 1, 26'h102);
      tbl[11] = mk(1, 0, 26'h0,      26'h101,    0, 0, 0,  1, 1, 1, 26'h102);
      // clock enable low: commit and request must be frozen out
      tbl[12] = mk(0, 0, 26'h0,      26'h101,    1, 1, 0,  1, 1, 1, 26'h102);
      tbl[13] = mk(1, 0, 26'h0,      26'h101,    0, 0, 0,  1, 1, 1, 26'h102);
      tbl[14] = mk(1, 0, 26'h0,      26'h101,    1, 0, 0,  1, 1, 1, 26'h102);
      // hit commit with nothing present, commit with nothing in flight: ignored
      tbl[15] = mk(1, 0, 26'h0,      26'h102,    1, 0, 0,  0, 1, 1, 26'h102);
      tbl[16] = mk(1, 0, 26'h0,      26'h102,    0, 0, 1,  0, 1, 1, 26'h102);
      tbl[17] = mk(1, 0, 26'h0,      26'h102,    0, 0, 0,  0, 1, 1, 26'h102);
      // address wrap
      tbl[18] = mk(1, 1, 26'h3FFFFFF, 26'h0,     0, 0, 0,  0, 1, 1, 26'h102);
      tbl[19] = mk(1, 0, 26'h0,      26'h3FFFFFF, 0, 1, 0, 0, 1, 1, 26'h3FFFFFF);
      tbl[20] = mk(1, 0, 26'h0,      26'h3FFFFFF, 0, 0, 0, 0, 1, 1, 26'h0);
      // simultaneous events
      tbl[21] = mk(1, 0, 26'h0,      26'h3FFFFFF, 0, 1, 1, 0, 1, 1, 26'h0);
      tbl[22] = mk(1, 0, 26'h0,      26'h3FFFFFF, 1, 1, 1, 1, 0, 1, 26'h1);
      tbl[23] = mk(1, 0, 26'h0,      26'h0,      0, 0, 0,  1, 1, 1, 26'h1);
      tbl[24] = mk(1, 0, 26'h0,      26'h0,      0, 1, 0,  1, 1, 1, 26'h1);
      // reallocation with one prefetch in flight
      tbl[25] = mk(1, 1, 26'h200,    26'h0,      0, 0, 0,  1, 0, 1, 26'h2);
      tbl[26] = mk(1, 0, 26'h0,      26'h200,    0, 0, 1,  0, 1, !STALE, 26'h200);
      tbl[27] = mk(1, 0, 26'h0,      26'h200,    0, 0, 0,  0, 1, 1, 26'h200);

      // Reset asserted with ENB and BUFFER_RESET high: reset must win
      rst = 1'b1;
      sbif.ENB = 1'b1; sbif.BUFFER_RESET = 1'b1; sbif.INIT_TOQ_VALUE = 26'h55;
      sbif.ADDR_IN = 26'h55; sbif.HIT_COMMIT = 1'b0;
      sbif.PREFETCH_REQUESTED = 1'b1; sbif.PREFETCH_COMMITED = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_outs("reset", 0, 0, 0, 26'h0);
      sbif.BUFFER_RESET = 1'b0; sbif.PREFETCH_REQUESTED = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 28; i++) apply(tbl[i], $sformatf("v%0d", i));

      // Reallocation with two prefetches in flight: both arrivals belong to the old stream
      apply(mk(1, 0, 26'h0,   26'h200, 0, 1, 0,  0, 1, 1, 26'h200), "s0");
      apply(mk(1, 0, 26'h0,   26'h200, 0, 1, 0,  0, 1, 1, 26'h201), "s1");
      apply(mk(1, 1, 26'h200, 26'h200, 0, 0, 0,  0, 0, 1, 26'h202), "s2");
      apply(mk(1, 0, 26'h0,   26'h200, 0, 0, 1,  0, 1, !STALE, 26'h200), "s3");
      apply(mk(1, 0, 26'h0,   26'h200, 0, 0, 1,  0, 1, !STALE, 26'h200), "s4");
      apply(mk(1, 0, 26'h0,   26'h200, 0, 1, 0,  0, 1, 1, 26'h200), "s5");
      apply(mk(1, 0, 26'h0,   26'h200, 0, 0, 1,  0, 1, 1, 26'h201), "s6");
      apply(mk(1, 0, 26'h0,   26'h200, 0, 0, 0,  1, 1, 1, 26'h201), "s7");

      // Asynchronous reset mid-cycle clears everything without waiting for an edge
      @(negedge clk);
      sbif.ENB = 1'b1; sbif.BUFFER_RESET = 1'b0; sbif.ADDR_IN = 26'h200;
      sbif.HIT_COMMIT = 1'b0; sbif.PREFETCH_REQUESTED = 1'b0; sbif.PREFETCH_COMMITED = 1'b0;
      #2 rst = 1'b1;
      #1 check_outs("async_rst", 0, 0, 0, 26'h0);
      @(negedge clk);
      rst = 1'b0;
      #1 check_outs("post_rst", 0, 0, 0, 26'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
